pipe_reg_chain: RTL
===================

# pipe_reg_chain

Parametrised elastic register pipeline: a chain of `DEPTH` data registers, each `WIDTH` bits wide with its own valid bit, joined by a valid/ready handshake. It replaces single-bit flip-flops wherever a multi-cycle, stallable, flushable delay line is needed between producer and consumer blocks. Bubbles collapse, so a stalled output does not stop upstream stages from filling empty slots. It provides an asynchronous reset, a synchronous active-low flush and an occupancy count.

## Interface
- `WIDTH`, 8: data bits per stage, ≥1.
- `DEPTH`, 4: number of register stages, ≥1.
- `RESET_VAL`, 0: value loaded into every data register on reset or flush.
- `CW`, $clog2(DEPTH+1): derived width of `count`; not overridden.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clr_n`  in  1: synchronous flush, active-low.
- `in_valid`  in  1: producer offers `in_data`.
- `in_ready`  out  1: stage 0 can accept.
- `in_data`  in  WIDTH: producer data.
- `out_valid`  out  1: last stage holds data.
- `out_ready`  in  1: consumer accepts.
- `out_data`  out  WIDTH: last-stage data.
- `count`  out  CW: number of valid stages, 0..DEPTH.

## Operation
- Stage i holds `v[i]` and `d[i]`. Stage 0 is the input and stage DEPTH-1 is the output.
- Ready chain: `rdy[DEPTH-1] = !v[DEPTH-1] || out_ready`, and `rdy[i] = !v[i] || rdy[i+1]`. `in_ready = rdy[0]`.
- The path from `out_ready` to `in_ready` is purely combinational. This is intentional, so that bubbles collapse.
- Stage i loads when `rdy[i]` is 1:
  - `v[i] <= v[i-1]` and `d[i] <= d[i-1]`.
  - For stage 0, the sources are `in_valid` and `in_data`.
  - A stage with `rdy[i]` = 0 holds its contents.
- `d[i]` is written only when the incoming valid is 1. A bubble moving in leaves the data unchanged; only the valid bit clears.
- Transfers:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
  - Data order is strictly preserved. No word is dropped or duplicated.
- `count` is registered. Its next value is count + in_xfer − out_xfer. Simultaneous input and output transfers leave it unchanged.
- Flush: when `clr_n` is 0 at a rising edge:
  - All `v` and `count` clear.
  - All `d` load `RESET_VAL`.
  - `in_data` is not captured.
  - While `clr_n` is 0, `in_ready` and `out_valid` are forced to 0 combinationally, so no transfer is counted in that cycle.
- Reset: when `reset` is 1, the block asynchronously sets all `v` and `count` to 0 and all `d` to `RESET_VAL`.
  - `reset` has priority over `clr_n`.
  - On reset deassertion, operation resumes on the next edge.
- Reset values of outputs:
  - `out_valid` = 0, `out_data` = `RESET_VAL`, `count` = 0.
  - `in_ready` = 1 (while `clr_n` = 1).
- Boundary conditions:
  - Full (count = DEPTH) with `out_ready` = 0: `in_ready` = 0.
  - Full with `out_ready` = 1: `in_ready` = 1, and throughput is one word per cycle.
  - Empty: `out_valid` = 0, and `out_data` holds the last value.
  - DEPTH = 1: `in_ready = !v[0] || out_ready`.

## Timing
- Latency from input transfer to `out_valid` is exactly DEPTH cycles when never stalled.
- With `out_ready` held at 1, sustained throughput is 1 word/cycle.
- `count` updates on the edge following the transfer.
- Combinational paths:
  - `out_ready`/`clr_n` → `in_ready`, a depth-proportional ready chain.
  - `clr_n` → `out_valid`.
  - There is no path from `in_valid` to `out_*`.

## Structure
- The shared package `pipe_pkg` holds `pipe_cnt_w(depth)`, the count-width function.
- Sub-module `pipe_stage` (WIDTH, RESET_VAL) holds one valid+data register.
  - Inputs: `clk`, `reset`, `clr_n`, `up_valid`, `up_data`, `dn_ready`.
  - Outputs: `valid`, `data`, `ready`.
- Stages are instantiated in a generate loop. The count register lives in the top.

## Test plan
- Reset with WIDTH=8, DEPTH=4: assert `reset` mid-stream with count=3. Immediately `out_valid`=0, `count`=0 and `out_data`=RESET_VAL, with no clock edge needed.
- Streaming: `out_ready`=1, push 0x01..0x0A on consecutive cycles. `out_data`=0x01 appears 4 cycles after its push, followed by the rest in order. `count` holds 4 in steady state.
- Fill and stall: `out_ready`=0, push 0xA0..0xA5. Only 0xA0..0xA3 are accepted; `in_ready`=0 after the 4th, and `count`=4. Raising `out_ready` drains 0xA0 first.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, all with `out_ready`=0. Both end up packed in stages 3 and 2 with `count`=2, and `in_ready` stays 1.
- Full plus simultaneous transfer: count=4, `in_valid`=`out_ready`=1 for 3 cycles. Exactly 3 words go in and 3 come out, and `count` stays at 4.
- Flush: count=3, `clr_n`=0 for 1 cycle with `in_valid`=1. During that cycle `in_ready`=0 and `out_valid`=0. After the edge, `count`=0, nothing is captured, and the next push appears after 4 cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
// pipe_cnt_w sizes an occupancy counter that must represent 0..depth inclusive.
package pipe_pkg;

  function automatic int pipe_cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a data register.
// The slot loads whenever it is empty or its downstream neighbour can take its word.
module pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = !valid || dn_ready;

  // Data is written only for a real word, so a bubble leaves the last value visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (!clr_n) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Stallable, flushable elastic delay line of DEPTH pipe_stage slots with occupancy count.
// Empty slots accept data even while the output is stalled, so bubbles collapse.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = pipe_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Handshake: a word moves across a port on a rising edge where valid and ready are
  // both 1; valid never depends on ready, while ready may depend on the far-side ready.
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] dn;
  logic [WIDTH-1:0] d [DEPTH];
  logic             all_full;
  logic             in_xfer;
  logic             out_xfer;
  logic             unused_rdy;

  // Stage i may pass its word on unless every later stage is full and the output stalls;
  // this equals the recursive ready chain but is formed without a feedback net.
  always_comb begin
    all_full = 1'b1;
    dn       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      dn[i]    = out_ready || !all_full;
      all_full = all_full && v[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (i == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_d = d[i-1];
    end
    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clr_n    (clr_n),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (dn[i]),
      .valid    (v[i]),
      .data     (d[i]),
      .ready    (rdy[i])
    );
  end

  assign unused_rdy = ^rdy;

  assign in_ready  = clr_n && rdy[0];
  assign out_valid = clr_n && v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!clr_n) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule
